osc_phase_gen: RTL and testbench

Time-multiplexed phase accumulator bank directly upstream of the wave loader. Converts per-oscillator fixed-point phase increments into integer sample indices that wrap at the current wave width. Produces a coherent, double-buffered index set once per audio sample tick for the loader's per-oscillator read ports. One oscillator is updated per clock, so one adder serves all oscillators.

---
 rtl/osc_phase_gen.sv | 199 +++++++++++++++++++
 tb/tb_osc_phase_gen.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_phase_gen.sv
// Time-multiplexed phase accumulator bank: one oscillator per clock, one shared adder, double-buffered index publish.
// Optional macro OSC_FRAC_OUT_EN adds osc_frac_out carrying the fractional phase, published with the indices.
module osc_phase_gen #(
    parameter int NUM_OSCILLATORS = 4,
    parameter int WW_WIDTH        = 18,
    parameter int FRAC_WIDTH      = 14,
    parameter int INC_WIDTH       = 32
) (
    input  logic                                         clk_in,
    input  logic                                         rst_in,
    input  logic                                         sample_tick_in,
    input  logic                                         ui_update_trig_in,
    input  logic [WW_WIDTH-1:0]                          wave_width_in,
    input  logic [NUM_OSCILLATORS-1:0]                   osc_is_on_in,
    input  logic [NUM_OSCILLATORS-1:0][INC_WIDTH-1:0]    osc_incr_in,
    output logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]     osc_index_out,
`ifdef OSC_FRAC_OUT_EN
    output logic [NUM_OSCILLATORS-1:0][FRAC_WIDTH-1:0]   osc_frac_out,
`endif
    output logic                                         sample_valid_out,
    output logic                                         busy_out,
    output logic                                         overrun_out
);

    localparam int PH_WIDTH   = WW_WIDTH + FRAC_WIDTH;
    localparam int SLOT_WIDTH = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_UPDATE  = 2'd1;
    localparam logic [1:0] ST_PUBLISH = 2'd2;

    localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(NUM_OSCILLATORS - 1);

    logic [1:0]            state_r;
    logic [1:0]            state_next_s;
    logic [SLOT_WIDTH-1:0] slot_r;
    logic                  pending_r;
    logic                  pending_next_s;
    logic                  overrun_next_s;

    logic [PH_WIDTH-1:0]   phase_r      [NUM_OSCILLATORS];
    logic [WW_WIDTH-1:0]   shadow_idx_r [NUM_OSCILLATORS];
`ifdef OSC_FRAC_OUT_EN
    logic [FRAC_WIDTH-1:0] shadow_frac_r [NUM_OSCILLATORS];
`endif

    logic [PH_WIDTH-1:0]   incr_s;
    logic [PH_WIDTH:0]     sum_s;
    logic [PH_WIDTH:0]     wrap_s;
    logic [PH_WIDTH:0]     ww_shift_s;
    logic [WW_WIDTH:0]     ww_ext_s;
    logic [PH_WIDTH-1:0]   next_phase_s;
    logic                  last_slot_s;
    logic                  publish_s;
    logic                  clear_out_s;

    // Shared adder for the oscillator in the current slot, with single-subtract wrap and fallback to zero
    always_comb begin
        incr_s     = PH_WIDTH'(osc_incr_in[slot_r]);
        ww_ext_s   = {1'b0, wave_width_in};
        ww_shift_s = {1'b0, wave_width_in, {FRAC_WIDTH{1'b0}}};
        sum_s      = {1'b0, phase_r[slot_r]} + {1'b0, incr_s};
        if (sum_s[PH_WIDTH:FRAC_WIDTH] >= ww_ext_s) begin
            wrap_s = sum_s - ww_shift_s;
        end else begin
            wrap_s = sum_s;
        end
        if (!osc_is_on_in[slot_r] || (wave_width_in == {WW_WIDTH{1'b0}})
            || (wrap_s[PH_WIDTH:FRAC_WIDTH] >= ww_ext_s)) begin
            next_phase_s = {PH_WIDTH{1'b0}};
        end else begin
            next_phase_s = wrap_s[PH_WIDTH-1:0];
        end
    end

    // Publish strobe and output-clear decode
    always_comb begin
        last_slot_s = (slot_r == LAST_SLOT);
        publish_s   = (state_r == ST_UPDATE) && last_slot_s && !ui_update_trig_in;
        clear_out_s = ui_update_trig_in && (state_r != ST_UPDATE);
    end

    // Next-state, pending and overrun logic; the reload strobe outranks every tick
    always_comb begin
        state_next_s   = state_r;
        pending_next_s = pending_r;
        overrun_next_s = overrun_out;
        if (ui_update_trig_in) begin
            state_next_s   = ST_IDLE;
            pending_next_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sample_tick_in || pending_r) begin
                        state_next_s   = ST_UPDATE;
                        pending_next_s = 1'b0;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_UPDATE: begin
                    if (last_slot_s) begin
                        state_next_s = ST_PUBLISH;
                    end else begin
                        state_next_s = ST_UPDATE;
                    end
                end
                ST_PUBLISH: begin
                    state_next_s = ST_IDLE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
            // A tick that finds a request already queued is lost
            if (sample_tick_in && pending_r) begin
                overrun_next_s = 1'b1;
            end else if (sample_tick_in && (state_r != ST_IDLE)) begin
                pending_next_s = 1'b1;
            end else begin
                overrun_next_s = overrun_out;
            end
        end
    end

    // Control state: FSM, slot counter, pending and sticky overrun flags
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r     <= ST_IDLE;
            slot_r      <= {SLOT_WIDTH{1'b0}};
            pending_r   <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pending_r   <= pending_next_s;
            overrun_out <= overrun_next_s;
            if ((state_r == ST_UPDATE) && !ui_update_trig_in && !last_slot_s) begin
                slot_r <= slot_r + SLOT_WIDTH'(1);
            end else begin
                slot_r <= {SLOT_WIDTH{1'b0}};
            end
        end
    end

    // Phase accumulators and shadow buffer, one slot written per UPDATE cycle
    always_ff @(posedge clk_in) begin
        if (!rst_in || ui_update_trig_in) begin
            for (int k = 0; k < NUM_OSCILLATORS; k++) begin
                phase_r[k]      <= {PH_WIDTH{1'b0}};
                shadow_idx_r[k] <= {WW_WIDTH{1'b0}};
`ifdef OSC_FRAC_OUT_EN
                shadow_frac_r[k] <= {FRAC_WIDTH{1'b0}};
`endif
            end
        end else if (state_r == ST_UPDATE) begin
            phase_r[slot_r]      <= next_phase_s;
            shadow_idx_r[slot_r] <= next_phase_s[PH_WIDTH-1:FRAC_WIDTH];
`ifdef OSC_FRAC_OUT_EN
            shadow_frac_r[slot_r] <= next_phase_s[FRAC_WIDTH-1:0];
`endif
        end
    end

    // Published outputs; the last slot bypasses the shadow so the whole set lands with the valid pulse
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            osc_index_out    <= '0;
`ifdef OSC_FRAC_OUT_EN
            osc_frac_out     <= '0;
`endif
            sample_valid_out <= 1'b0;
            busy_out         <= 1'b0;
        end else begin
            sample_valid_out <= (state_next_s == ST_PUBLISH);
            busy_out         <= (state_next_s != ST_IDLE);
            if (clear_out_s) begin
                osc_index_out <= '0;
`ifdef OSC_FRAC_OUT_EN
                osc_frac_out  <= '0;
`endif
            end else if (publish_s) begin
                for (int j = 0; j < NUM_OSCILLATORS; j++) begin
                    if (j == NUM_OSCILLATORS - 1) begin
                        osc_index_out[j] <= next_phase_s[PH_WIDTH-1:FRAC_WIDTH];
`ifdef OSC_FRAC_OUT_EN
                        osc_frac_out[j]  <= next_phase_s[FRAC_WIDTH-1:0];
`endif
                    end else begin
                        osc_index_out[j] <= shadow_idx_r[j];
`ifdef OSC_FRAC_OUT_EN
                        osc_frac_out[j]  <= shadow_frac_r[j];
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_osc_phase_gen.sv
// Self-checking bench for osc_phase_gen: directed scenarios plus randomized ticks against a behavioural phase model.
module tb_osc_phase_gen;

    localparam int N  = 4;
    localparam int WW = 18;
    localparam int F  = 14;
    localparam int IW = 32;
    localparam int PW = WW + F;

    logic                      clk_in = 1'b0;
    logic                      rst_in;
    logic                      sample_tick_in;
    logic                      ui_update_trig_in;
    logic [WW-1:0]             wave_width_in;
    logic [N-1:0]              osc_is_on_in;
    logic [N-1:0][IW-1:0]      osc_incr_in;
    logic [N-1:0][WW-1:0]      osc_index_out;
`ifdef OSC_FRAC_OUT_EN
    logic [N-1:0][F-1:0]       osc_frac_out;
`endif
    logic                      sample_valid_out;
    logic                      busy_out;
    logic                      overrun_out;

    int checks = 0;
    int errors = 0;

    longint unsigned m_phase    [N];
    longint unsigned m_pub_idx  [N];
    longint unsigned m_pub_frac [N];

    osc_phase_gen #(
        .NUM_OSCILLATORS(N), .WW_WIDTH(WW), .FRAC_WIDTH(F), .INC_WIDTH(IW)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .sample_tick_in(sample_tick_in),
        .ui_update_trig_in(ui_update_trig_in),
        .wave_width_in(wave_width_in),
        .osc_is_on_in(osc_is_on_in),
        .osc_incr_in(osc_incr_in),
        .osc_index_out(osc_index_out),
`ifdef OSC_FRAC_OUT_EN
        .osc_frac_out(osc_frac_out),
`endif
        .sample_valid_out(sample_valid_out),
        .busy_out(busy_out),
        .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One sample period of every oscillator: add, wrap once, give up to zero if still out of range
    function automatic void model_tick();
        longint unsigned w;
        longint unsigned s;
        longint unsigned mask;
        mask = (64'd1 << PW) - 64'd1;
        w = longint'(wave_width_in);
        for (int k = 0; k < N; k++) begin
            if (!osc_is_on_in[k] || w == 64'd0) begin
                s = 64'd0;
            end else begin
                s = m_phase[k] + (longint'(osc_incr_in[k]) & mask);
                if ((s >> F) >= w) s = s - (w << F);
                if ((s >> F) >= w) s = 64'd0;
            end
            m_phase[k]    = s;
            m_pub_idx[k]  = s >> F;
            m_pub_frac[k] = s & ((64'd1 << F) - 64'd1);
        end
    endfunction

    function automatic void model_zero(input bit clear_pub);
        for (int k = 0; k < N; k++) begin
            m_phase[k] = 64'd0;
            if (clear_pub) begin
                m_pub_idx[k]  = 64'd0;
                m_pub_frac[k] = 64'd0;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_trig();
        ui_update_trig_in = 1'b1;
        step();
        ui_update_trig_in = 1'b0;
    endtask

    // Issue one tick from IDLE, return how many cycles later sample_valid_out rose (-1 if never)
    task automatic do_tick(output int lat, output logic busy_first);
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        lat = -1;
        busy_first = 1'b0;
        for (int c = 1; c <= N + 8; c++) begin
            @(negedge clk_in);
            if (c == 1) busy_first = busy_out;
            if (sample_valid_out) begin
                lat = c;
                break;
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        sample_tick_in = 1'b0;
        ui_update_trig_in = 1'b0;
        wave_width_in = '0;
        osc_is_on_in = '0;
        osc_incr_in = '0;
        repeat (3) step();
        @(negedge clk_in);
        checks++;
        if (osc_index_out !== '0) begin
            errors++; $display("FAIL reset_index: got %h expected 0", osc_index_out);
        end
        checks++;
        if ({sample_valid_out, busy_out, overrun_out} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {sample_valid_out, busy_out, overrun_out});
        end
`ifdef OSC_FRAC_OUT_EN
        checks++;
        if (osc_frac_out !== '0) begin
            errors++; $display("FAIL reset_frac: got %h expected 0", osc_frac_out);
        end
`endif
        rst_in = 1'b1;
        step();
        model_zero(1'b1);
    endtask

    task automatic test_integer_step();
        int lat;
        logic b1;
        wave_width_in = 18'd8;
        osc_is_on_in = 4'b1101;
        osc_incr_in[0] = 32'h0000_4000;
        osc_incr_in[1] = 32'h0000_4000;
        osc_incr_in[2] = 32'h0000_6000;
        osc_incr_in[3] = 32'h0000_0000;
        for (int i = 0; i < 10; i++) begin
            do_tick(lat, b1);
            model_tick();
            checks++;
            if (lat !== N + 1) begin
                errors++; $display("FAIL int_latency tick %0d: got %0d expected %0d", i, lat, N + 1);
            end
            checks++;
            if (b1 !== 1'b1) begin
                errors++; $display("FAIL int_busy tick %0d: got %b expected 1", i, b1);
            end
            checks++;
            if (osc_index_out[0] !== WW'((i + 1) % 8)) begin
                errors++; $display("FAIL int_seq tick %0d: got %0d expected %0d", i, osc_index_out[0], (i + 1) % 8);
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (osc_index_out[k] !== WW'(m_pub_idx[k])) begin
                    errors++; $display("FAIL int_index[%0d] tick %0d: got %0d expected %0d", k, i, osc_index_out[k], m_pub_idx[k]);
                end
            end
        end
    endtask

    task automatic test_half_step();
        int lat;
        logic b1;
        pulse_trig();
        model_zero(1'b1);
        @(negedge clk_in);
        checks++;
        if (osc_index_out !== '0) begin
            errors++; $display("FAIL half_trig_clear: got %h expected 0", osc_index_out);
        end
        step();
        osc_is_on_in = 4'b1111;
        osc_incr_in[0] = 32'h0000_2000;
        osc_incr_in[1] = 32'h0000_1000;
        osc_incr_in[2] = 32'h0000_A000;
        osc_incr_in[3] = 32'h0001_3000;
        for (int i = 1; i <= 6; i++) begin
            do_tick(lat, b1);
            model_tick();
            checks++;
            if (osc_index_out[0] !== WW'((i / 2) % 8)) begin
                errors++; $display("FAIL half_seq tick %0d: got %0d expected %0d", i, osc_index_out[0], (i / 2) % 8);
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (osc_index_out[k] !== WW'(m_pub_idx[k])) begin
                    errors++; $display("FAIL half_index[%0d] tick %0d: got %0d expected %0d", k, i, osc_index_out[k], m_pub_idx[k]);
                end
            end
`ifdef OSC_FRAC_OUT_EN
            checks++;
            if (osc_frac_out[0] !== ((i % 2) ? 14'h2000 : 14'h0000)) begin
                errors++; $display("FAIL half_frac tick %0d: got %h", i, osc_frac_out[0]);
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (osc_frac_out[k] !== F'(m_pub_frac[k])) begin
                    errors++; $display("FAIL half_frac[%0d] tick %0d: got %h expected %h", k, i, osc_frac_out[k], m_pub_frac[k]);
                end
            end
`endif
        end
    endtask

    task automatic test_wrap();
        int lat;
        logic b1;
        int exp_seq [4] = '{2, 4, 6, 0};
        pulse_trig();
        model_zero(1'b1);
        osc_is_on_in = 4'b1111;
        osc_incr_in[0] = 32'h0002_8000;
        osc_incr_in[1] = 32'h0001_C000;
        osc_incr_in[2] = 32'h0000_4000;
        osc_incr_in[3] = 32'h0003_C000;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) osc_incr_in[0] = 32'h0008_0000;
            do_tick(lat, b1);
            model_tick();
            checks++;
            if (osc_index_out[0] !== WW'((i < 4) ? exp_seq[i] : 0)) begin
                errors++; $display("FAIL wrap_seq tick %0d: got %0d", i, osc_index_out[0]);
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (osc_index_out[k] !== WW'(m_pub_idx[k])) begin
                    errors++; $display("FAIL wrap_index[%0d] tick %0d: got %0d expected %0d", k, i, osc_index_out[k], m_pub_idx[k]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int pulses;
        osc_incr_in[0] = 32'h0000_4000;
        osc_incr_in[1] = 32'h0000_2000;
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        step();
        sample_tick_in = 1'b1;
        step();
        step();
        sample_tick_in = 1'b0;
        pulses = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk_in);
            if (sample_valid_out) pulses++;
        end
        step();
        model_tick();
        model_tick();
        checks++;
        if (pulses !== 2) begin
            errors++; $display("FAIL overrun_pulses: got %0d expected 2", pulses);
        end
        checks++;
        if (overrun_out !== 1'b1) begin
            errors++; $display("FAIL overrun_flag: got %b expected 1", overrun_out);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (osc_index_out[k] !== WW'(m_pub_idx[k])) begin
                errors++; $display("FAIL overrun_index[%0d]: got %0d expected %0d", k, osc_index_out[k], m_pub_idx[k]);
            end
        end
        repeat (5) step();
        checks++;
        if (overrun_out !== 1'b1) begin
            errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun_out);
        end
        rst_in = 1'b0;
        step();
        rst_in = 1'b1;
        model_zero(1'b1);
        checks++;
        if (overrun_out !== 1'b0) begin
            errors++; $display("FAIL overrun_reset: got %b expected 0", overrun_out);
        end
    endtask

    task automatic test_trig_abort();
        int lat;
        logic b1;
        int pulses;
        wave_width_in = 18'd8;
        osc_is_on_in = 4'b1111;
        for (int k = 0; k < N; k++) osc_incr_in[k] = IW'((k + 1) * 32'h4000);
        do_tick(lat, b1);
        model_tick();
        do_tick(lat, b1);
        model_tick();
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        step();
        step();
        ui_update_trig_in = 1'b1;
        step();
        ui_update_trig_in = 1'b0;
        model_zero(1'b0);
        pulses = 0;
        for (int c = 0; c < N + 4; c++) begin
            @(negedge clk_in);
            if (sample_valid_out) pulses++;
        end
        step();
        checks++;
        if (pulses !== 0 || busy_out !== 1'b0) begin
            errors++; $display("FAIL abort_pulse: got %0d pulses busy %b expected 0 pulses busy 0", pulses, busy_out);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (osc_index_out[k] !== WW'(m_pub_idx[k])) begin
                errors++; $display("FAIL abort_hold[%0d]: got %0d expected %0d", k, osc_index_out[k], m_pub_idx[k]);
            end
        end
        do_tick(lat, b1);
        model_tick();
        checks++;
        if (lat !== N + 1) begin
            errors++; $display("FAIL abort_latency: got %0d expected %0d", lat, N + 1);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (osc_index_out[k] !== WW'(k + 1)) begin
                errors++; $display("FAIL abort_restart[%0d]: got %0d expected %0d", k, osc_index_out[k], k + 1);
            end
        end
    endtask

    task automatic test_osc_off();
        int lat;
        logic b1;
        pulse_trig();
        model_zero(1'b1);
        wave_width_in = 18'd8;
        osc_is_on_in = 4'b1101;
        for (int k = 0; k < N; k++) osc_incr_in[k] = 32'h0000_4000;
        for (int i = 1; i <= 3; i++) begin
            do_tick(lat, b1);
            model_tick();
            checks++;
            if (osc_index_out[1] !== 18'd0 || osc_index_out[0] !== WW'(i)) begin
                errors++; $display("FAIL off_index tick %0d: got %0d/%0d expected %0d/0", i, osc_index_out[0], osc_index_out[1], i);
            end
        end
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        step();
        rst_in = 1'b0;
        step();
        @(negedge clk_in);
        checks++;
        if (osc_index_out !== '0 || {sample_valid_out, busy_out, overrun_out} !== 3'b000) begin
            errors++; $display("FAIL midreset: got %h flags %b expected 0 flags 000", osc_index_out, {sample_valid_out, busy_out, overrun_out});
        end
        rst_in = 1'b1;
        step();
        model_zero(1'b1);
    endtask

    task automatic test_random();
        int lat;
        logic b1;
        int sel;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                pulse_trig();
                model_zero(1'b1);
            end
            sel = $urandom_range(0, 9);
            if (sel == 0) wave_width_in = '0;
            else if (sel < 6) wave_width_in = WW'($urandom_range(1, 64));
            else wave_width_in = WW'($urandom_range(1, 262143));
            osc_is_on_in = N'($urandom);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) osc_incr_in[k] = $urandom;
                else osc_incr_in[k] = $urandom_range(0, 32'h000F_FFFF);
            end
            do_tick(lat, b1);
            model_tick();
            checks++;
            if (lat !== N + 1) begin
                errors++; $display("FAIL rand_latency it %0d: got %0d expected %0d", it, lat, N + 1);
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (osc_index_out[k] !== WW'(m_pub_idx[k])) begin
                    errors++; $display("FAIL rand_index[%0d] it %0d: got %0d expected %0d", k, it, osc_index_out[k], m_pub_idx[k]);
                end
`ifdef OSC_FRAC_OUT_EN
                checks++;
                if (osc_frac_out[k] !== F'(m_pub_frac[k])) begin
                    errors++; $display("FAIL rand_frac[%0d] it %0d: got %h expected %h", k, it, osc_frac_out[k], m_pub_frac[k]);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_integer_step();
        test_half_step();
        test_wrap();
        test_overrun();
        test_trig_abort();
        test_osc_off();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
